// File: rtl/mac_array_ctrl.sv
// rtl/mac_array_ctrl.sv - sequencer for the systolic MAC array (kernel load, execute, drain)
//
// Purpose
//   Runs one job per accepted start: loads the kernel (weight SRAM reads for
//   col cycles), idles one gap cycle, streams len activation vectors, then
//   waits for len result pulses from the bottom row before pulsing done.
//   The 2-bit instruction {execute, load} follows the SRAM read strobes by one
//   cycle (read latency) and is skewed one extra cycle per row.
//
// Ports
//   clk       in   1          rising-edge clock
//   reset     in   1          asynchronous active-low reset
//   start     in   1          job request, honoured only while idle
//   len       in   len_bw     activation vector count, captured with start
//   valid_in  in   1          bottom-row column-0 result valid
//   busy      out  1          job in progress (high until the cycle after done)
//   done      out  1          one-cycle completion pulse
//   w_rd_en   out  1          weight SRAM read enable
//   w_addr    out  wa_bw      weight SRAM address
//   a_rd_en   out  1          activation SRAM read enable
//   a_addr    out  len_bw     activation SRAM address
//   inst_w    out  2*row      per-row inst lane, row r at [2r+1:2r]

module mac_array_ctrl #(
   parameter int row    = 8,
   parameter int col    = 8,
   parameter int len_bw = 8,
   parameter int wa_bw  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [len_bw-1:0] len,
   input  logic              valid_in,
   output logic              busy,
   output logic              done,
   output logic              w_rd_en,
   output logic [wa_bw-1:0]  w_addr,
   output logic              a_rd_en,
   output logic [len_bw-1:0] a_addr,
   output logic [2*row-1:0]  inst_w
);

   // One shared phase counter walks both address ranges.
   localparam int CW = (len_bw > wa_bw) ? len_bw : wa_bw;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_GAP,
      S_EXEC,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [CW-1:0]       r_cnt;
   logic [CW-1:0]       w_cnt_nxt;
   logic [len_bw-1:0]   r_len_q;
   logic [len_bw-1:0]   w_len_q_nxt;
   logic [len_bw-1:0]   w_len_m1;
   logic [len_bw:0]     r_out_cnt;
   logic [len_bw:0]     w_out_cnt_nxt;
   logic [len_bw:0]     w_out_cnt_inc;
   logic                w_count_vld;

   logic                w_busy_nxt;
   logic                w_done_nxt;
   logic                w_w_rd_en_nxt;
   logic                w_a_rd_en_nxt;
   logic [wa_bw-1:0]    w_w_addr_nxt;
   logic [len_bw-1:0]   w_a_addr_nxt;

   logic [row-1:0][1:0] r_pipe;

   assign w_len_m1 = r_len_q - 1'b1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_len_q   <= '0;
         r_out_cnt <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_len_q   <= w_len_q_nxt;
         r_out_cnt <= w_out_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_len_q_nxt = r_len_q;
      // Result pulses only belong to the job once activations are flowing.
      w_count_vld   = valid_in && (r_state == S_EXEC || r_state == S_DRAIN);
      w_out_cnt_inc = r_out_cnt + {{len_bw{1'b0}}, w_count_vld};
      w_out_cnt_nxt = w_out_cnt_inc;

      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt   = S_LOAD;
               w_cnt_nxt     = '0;
               w_len_q_nxt   = len;
               w_out_cnt_nxt = '0;
            end
         end
         S_LOAD: begin
            if (r_cnt == CW'(col - 1)) begin
               w_state_nxt = S_GAP;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         S_GAP: begin
            w_state_nxt = (r_len_q == '0) ? S_DONE : S_EXEC;
            w_cnt_nxt   = '0;
         end
         S_EXEC: begin
            if (r_cnt == CW'(w_len_m1)) begin
               w_state_nxt = S_DRAIN;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         S_DRAIN: begin
            // Includes this cycle's pulse so done follows the last pulse by
            // exactly one cycle; >= keeps a stray extra pulse from hanging us.
            if (w_out_cnt_inc >= {1'b0, r_len_q}) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      // Outputs are registered: decode them from the state being entered.
      w_busy_nxt    = (w_state_nxt != S_IDLE);
      w_done_nxt    = (w_state_nxt == S_DONE);
      w_w_rd_en_nxt = (w_state_nxt == S_LOAD);
      w_a_rd_en_nxt = (w_state_nxt == S_EXEC);
      w_w_addr_nxt  = w_w_rd_en_nxt ? w_cnt_nxt[wa_bw-1:0] : '0;
      w_a_addr_nxt  = w_a_rd_en_nxt ? w_cnt_nxt[len_bw-1:0] : '0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy    <= 1'b0;
         done    <= 1'b0;
         w_rd_en <= 1'b0;
         w_addr  <= '0;
         a_rd_en <= 1'b0;
         a_addr  <= '0;
         r_pipe  <= '0;
      end else begin
         busy    <= w_busy_nxt;
         done    <= w_done_nxt;
         w_rd_en <= w_w_rd_en_nxt;
         w_addr  <= w_w_addr_nxt;
         a_rd_en <= w_a_rd_en_nxt;
         a_addr  <= w_a_addr_nxt;
         // Lane 0 lags the strobes by the SRAM read latency; each further
         // row lags one more cycle. Shifts unconditionally so tails drain.
         r_pipe[0] <= {a_rd_en, w_rd_en};
         for (int r = 1; r < row; r++) begin
            r_pipe[r] <= r_pipe[r-1];
         end
      end
   end

   assign inst_w = r_pipe;

endmodule

// File: tb/tb_mac_array_ctrl.sv
// tb/tb_mac_array_ctrl.sv - randomized self-checking bench for mac_array_ctrl

module tb_mac_array_ctrl;

   localparam int ROW = 8;
   localparam int COL = 8;
   localparam int LBW = 8;
   localparam int WBW = 4;
   localparam int HN  = 8192;

   logic            clk = 1'b0;
   logic            reset;
   logic            start;
   logic [LBW-1:0]  len;
   logic            valid_in;
   logic            busy;
   logic            done;
   logic            w_rd_en;
   logic [WBW-1:0]  w_addr;
   logic            a_rd_en;
   logic [LBW-1:0]  a_addr;
   logic [2*ROW-1:0] inst_w;

   mac_array_ctrl #(
      .row    (ROW),
      .col    (COL),
      .len_bw (LBW),
      .wa_bw  (WBW)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .len      (len),
      .valid_in (valid_in),
      .busy     (busy),
      .done     (done),
      .w_rd_en  (w_rd_en),
      .w_addr   (w_addr),
      .a_rd_en  (a_rd_en),
      .a_addr   (a_addr),
      .inst_w   (inst_w)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model: a job is described by its cycle index m_k since
   // acceptance (1 = first LOAD cycle), its length, counted pulses and the
   // DONE cycle index once known (0 = not yet known).
   bit   m_busy = 0;
   int   m_k    = 0;
   int   m_len  = 0;
   int   m_cnt  = 0;
   int   m_dn   = 0;
   int   g      = 0;
   int   g_r    = -1;
   logic [1:0] hist [0:HN-1];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, g);
      end
   endtask

   task automatic step();
      bit w_e;
      bit a_e;
      int wa_e;
      int aa_e;
      int j;
      logic [1:0] lane_e;
      @(posedge clk);
      if (!reset) begin
         m_busy = 0;
      end else if (m_busy) begin
         if (valid_in && m_k >= COL + 2 && (m_dn == 0 || m_k < m_dn)) m_cnt++;
         if (m_dn == 0 && m_len != 0 && m_k >= COL + 2 + m_len && m_cnt >= m_len) m_dn = m_k + 1;
         if (m_dn != 0 && m_k == m_dn) m_busy = 0;
         else m_k++;
      end else if (start) begin
         m_busy = 1;
         m_k    = 1;
         m_len  = int'(len);
         m_cnt  = 0;
         m_dn   = (len == '0) ? COL + 2 : 0;
      end
      #1;
      g++;
      w_e  = m_busy && m_k <= COL;
      a_e  = m_busy && m_len != 0 && m_k >= COL + 2 && m_k <= COL + 1 + m_len;
      wa_e = w_e ? m_k - 1 : 0;
      aa_e = a_e ? m_k - COL - 2 : 0;
      chk("busy",    busy,    m_busy);
      chk("done",    done,    m_busy && m_dn != 0 && m_k == m_dn);
      chk("w_rd_en", w_rd_en, w_e);
      chk("w_addr",  w_addr,  wa_e);
      chk("a_rd_en", a_rd_en, a_e);
      chk("a_addr",  a_addr,  aa_e);
      if (g < HN) hist[g] = {a_e, w_e};
      for (int r = 0; r < ROW; r++) begin
         j = g - 1 - r;
         lane_e = (j >= 0 && j > g_r && j < HN) ? hist[j] : 2'b00;
         chk($sformatf("inst_w_row%0d", r), inst_w[2*r +: 2], lane_e);
         chk($sformatf("inst11_row%0d", r), inst_w[2*r +: 2] == 2'b11, 1'b0);
      end
   endtask

   task automatic drive_inputs(input bit spur);
      valid_in = 1'b0;
      start    = 1'b0;
      if (m_busy) begin
         if (m_k >= COL + 2 && (m_dn == 0 || m_k < m_dn)) begin
            if (m_cnt < m_len)
               valid_in = (m_k > COL + 1 + m_len) ? ($urandom_range(0, 1) == 0)
                                                  : ($urandom_range(0, 2) == 0);
         end else if (m_k <= COL + 1) begin
            valid_in = ($urandom_range(0, 3) == 0);
         end
         if (spur && $urandom_range(0, 5) == 0) begin
            start = 1'b1;
            len   = LBW'($urandom);
         end
         if (spur && m_dn != 0 && m_k == m_dn) start = 1'b1;
      end
   endtask

   task automatic run_job(input int l, input bit spur);
      int guard;
      start    = 1'b1;
      len      = LBW'(l);
      valid_in = 1'b0;
      step();
      start = 1'b0;
      guard = 0;
      while (m_busy && guard < 5000) begin
         drive_inputs(spur);
         step();
         guard++;
      end
      if (guard >= 5000) chk("job_timeout", guard, 0);
      start    = 1'b0;
      valid_in = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_busy"},    busy,    1'b0);
      chk({tag, "_done"},    done,    1'b0);
      chk({tag, "_w_rd_en"}, w_rd_en, 1'b0);
      chk({tag, "_w_addr"},  w_addr,  '0);
      chk({tag, "_a_rd_en"}, a_rd_en, 1'b0);
      chk({tag, "_a_addr"},  a_addr,  '0);
      chk({tag, "_inst_w"},  inst_w,  '0);
   endtask

   task automatic reset_mid_exec();
      start = 1'b1;
      len   = 8'd12;
      step();
      start = 1'b0;
      while (m_busy && m_k < COL + 2 + 5) begin
         drive_inputs(1'b0);
         step();
      end
      chk("a_addr_before_rst", a_addr, 5);
      #2 reset = 1'b0;
      #1;
      check_all_zero("async_rst");
      m_busy   = 0;
      g_r      = g;
      start    = 1'b1;
      valid_in = 1'b1;
      repeat (3) step();
      #2 reset = 1'b1;
      start    = 1'b0;
      valid_in = 1'b0;
      repeat (2) step();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < HN; i++) hist[i] = 2'b00;
      reset    = 1'b1;
      start    = 1'b1;
      len      = 8'd9;
      valid_in = 1'b1;
      #2 reset = 1'b0;
      #1;
      check_all_zero("reset");
      repeat (3) step();
      #2 reset = 1'b1;
      start    = 1'b0;
      valid_in = 1'b0;
      repeat (2) step();

      run_job(16, 1'b0);
      repeat (2) step();
      run_job(0, 1'b0);
      step();
      run_job(20, 1'b1);
      step();
      reset_mid_exec();
      run_job(16, 1'b0);
      run_job(10, 1'b0);
      run_job(10, 1'b1);
      run_job(1, 1'b0);

      for (int n = 0; n < 20; n++) begin
         run_job(int'($urandom_range(0, 40)), bit'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 2)) step();
      end
      repeat (ROW + 2) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
